// File: rtl/seg7_pkg.sv
// Shared definitions for the segment-chase display: mode encodings, active-low
// segment patterns and the position-to-(digit, segment) decoder.
`timescale 1ns/1ps
package seg7_pkg;

   typedef enum logic [1:0] {
      MODE_SPIN   = 2'b00,
      MODE_PERIM  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BLANK  = 2'b11
   } mode_t;

   // Active-low patterns, bit 6 = a ... bit 0 = g.
   localparam logic [6:0] SEG_A     = 7'b0111111;
   localparam logic [6:0] SEG_B     = 7'b1011111;
   localparam logic [6:0] SEG_C     = 7'b1101111;
   localparam logic [6:0] SEG_D     = 7'b1110111;
   localparam logic [6:0] SEG_E     = 7'b1111011;
   localparam logic [6:0] SEG_F     = 7'b1111101;
   localparam logic [6:0] SEG_G     = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Widest sequence is perimeter with 8 digits: 20 positions.
   localparam int POS_W = 5;

   typedef struct packed {
      logic [2:0] digit;
      logic [6:0] seg;
   } seg_loc_t;

   function automatic logic [POS_W-1:0] mode_len(input mode_t m, input int unsigned n_dig);
      logic [POS_W-1:0] len;
      case (m)
         MODE_SPIN:   len = POS_W'(6);
         MODE_PERIM:  len = POS_W'(2 * n_dig + 4);
         MODE_BOUNCE: len = POS_W'(n_dig);
         default:     len = POS_W'(1);
      endcase
      return len;
   endfunction

   function automatic seg_loc_t pos_decode(input mode_t m, input logic [POS_W-1:0] p,
                                           input int unsigned n_dig);
      seg_loc_t    loc;
      int unsigned pi;
      pi        = 32'(p);
      loc.digit = 3'd0;
      loc.seg   = SEG_BLANK;
      case (m)
         MODE_SPIN: begin
            case (pi)
               0:       loc.seg = SEG_A;
               1:       loc.seg = SEG_B;
               2:       loc.seg = SEG_C;
               3:       loc.seg = SEG_D;
               4:       loc.seg = SEG_E;
               5:       loc.seg = SEG_F;
               default: loc.seg = SEG_BLANK;
            endcase
         end
         MODE_PERIM: begin
            // Top edge right-to-left index order, down the right end, bottom edge, up the left end.
            if (pi < n_dig) begin
               loc.digit = 3'(n_dig - 1 - pi);
               loc.seg   = SEG_A;
            end else if (pi == n_dig) begin
               loc.seg = SEG_B;
            end else if (pi == n_dig + 1) begin
               loc.seg = SEG_C;
            end else if (pi < 2 * n_dig + 2) begin
               loc.digit = 3'(pi - (n_dig + 2));
               loc.seg   = SEG_D;
            end else if (pi == 2 * n_dig + 2) begin
               loc.digit = 3'(n_dig - 1);
               loc.seg   = SEG_E;
            end else if (pi == 2 * n_dig + 3) begin
               loc.digit = 3'(n_dig - 1);
               loc.seg   = SEG_F;
            end
         end
         MODE_BOUNCE: begin
            if (pi < n_dig) begin
               loc.digit = 3'(n_dig - 1 - pi);
               loc.seg   = SEG_G;
            end
         end
         default: begin
            loc.seg = SEG_BLANK;
         end
      endcase
      return loc;
   endfunction

endpackage

// File: rtl/seg_chase_mux_if.sv
// Control and display bundle for seg_chase_mux; pos is the live animation position.
`timescale 1ns/1ps
interface seg_chase_mux_if #(parameter int N_DIG = 4);
   import seg7_pkg::*;

   // No valid/ready: en/dir/mode are level controls sampled on every clk;
   // disp/anode are registered and change only on scan ticks; pos changes on step ticks.
   logic                en;
   logic                dir;
   mode_t               mode;
   logic [6:0]          disp;
   logic [N_DIG-1:0]    anode;
   logic [POS_W-1:0]    pos;

   modport master (output en, dir, mode, input disp, anode, pos);
   modport slave  (input en, dir, mode, output disp, anode, pos);
endinterface

// File: rtl/tick_div.sv
// Divide-by-DIV tick generator; counts only while en, clr restarts the count.
`timescale 1ns/1ps
module tick_div #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(DIV);

   logic [W-1:0] cnt;
   logic         wrap;

   assign wrap = (cnt == W'(DIV - 1));
   assign tick = en & wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/seg_chase_mux.sv
// Single-lit-segment chase animation over a multiplexed N_DIG-digit 7-segment
// display: spin, perimeter, bounce or blank, with free-running digit scan.
`timescale 1ns/1ps
module seg_chase_mux
   import seg7_pkg::*;
#(
   parameter int N_DIG    = 4,
   parameter int STEP_DIV = 25_000_000,
   parameter int SCAN_DIV = 50_000
) (
   input  logic            clk,
   input  logic            rst_n,
   seg_chase_mux_if.slave  bus
);
   logic             step_tick;
   logic             scan_tick;
   logic             mode_chg;

   mode_t            mode_q;
   logic [POS_W-1:0] pos, pos_nxt;
   logic             bflag, bflag_nxt;
   logic             binit, binit_nxt;
   logic [POS_W-1:0] last;
   logic             brev;

   logic [2:0]       scan_idx;
   logic [N_DIG-1:0] anode_q;
   logic [6:0]       disp_q;
   seg_loc_t         loc;

   assign mode_chg = (bus.mode != mode_q);

   tick_div #(.DIV(STEP_DIV)) u_step (
      .clk(clk), .rst_n(rst_n), .en(bus.en), .clr(mode_chg), .tick(step_tick)
   );

   tick_div #(.DIV(SCAN_DIV)) u_scan (
      .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .tick(scan_tick)
   );

   assign last = mode_len(mode_q, N_DIG) - 1'b1;
   assign brev = bflag ^ binit;

   // Bounce direction = flag XOR the dir captured on entry, so dir only seeds it.
   always_comb begin
      pos_nxt   = pos;
      bflag_nxt = bflag;
      binit_nxt = binit;
      if (mode_chg) begin
         pos_nxt   = '0;
         bflag_nxt = 1'b0;
         binit_nxt = bus.dir;
      end else if (step_tick && mode_q != MODE_BLANK) begin
         if (mode_q == MODE_BOUNCE) begin
            if (last != '0) begin
               if (!brev) begin
                  if (pos == last) begin
                     pos_nxt   = pos - 1'b1;
                     bflag_nxt = ~bflag;
                  end else begin
                     pos_nxt = pos + 1'b1;
                  end
               end else begin
                  if (pos == '0) begin
                     pos_nxt   = pos + 1'b1;
                     bflag_nxt = ~bflag;
                  end else begin
                     pos_nxt = pos - 1'b1;
                  end
               end
            end
         end else if (bus.dir) begin
            pos_nxt = (pos == '0) ? last : pos - 1'b1;
         end else begin
            pos_nxt = (pos == last) ? '0 : pos + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_SPIN;
         pos    <= '0;
         bflag  <= 1'b0;
         binit  <= 1'b0;
      end else begin
         mode_q <= bus.mode;
         pos    <= pos_nxt;
         bflag  <= bflag_nxt;
         binit  <= binit_nxt;
      end
   end

   assign loc = pos_decode(mode_q, pos, N_DIG);

   // Outputs latch the digit being selected now; the index moves on afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx <= 3'd0;
         anode_q  <= {N_DIG{1'b1}};
         disp_q   <= SEG_BLANK;
      end else if (scan_tick) begin
         anode_q  <= ~(N_DIG'(1) << scan_idx);
         disp_q   <= (loc.digit == scan_idx) ? loc.seg : SEG_BLANK;
         scan_idx <= (scan_idx == 3'(N_DIG - 1)) ? 3'd0 : scan_idx + 3'd1;
      end
   end

   assign bus.anode = anode_q;
   assign bus.disp  = disp_q;
   assign bus.pos   = pos;
endmodule

// File: tb/tb_seg_chase_mux.sv
// Directed bench for seg_chase_mux with N_DIG=4, STEP_DIV=4, SCAN_DIV=2.
`timescale 1ns/1ps
module tb_seg_chase_mux;
   import seg7_pkg::*;

   localparam int N_DIG = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   seg_chase_mux_if #(.N_DIG(N_DIG)) bus ();

   seg_chase_mux #(.N_DIG(N_DIG), .STEP_DIV(4), .SCAN_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [6:0] spin_exp [6] = '{7'b0111111, 7'b1011111, 7'b1101111,
                                7'b1110111, 7'b1111011, 7'b1111101};
   int bounce_dig [8] = '{3, 2, 1, 0, 1, 2, 3, 2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Enables stepping until pos moves, then pauses; the step counter is at 0 on entry.
   task automatic step_once(input string tag);
      logic [POS_W-1:0] old;
      int               n;
      old    = bus.pos;
      n      = 0;
      bus.en = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (bus.pos == old && n < 20);
      bus.en = 1'b0;
      chk({tag, " step latency"}, n, 4);
   endtask

   // After a full refresh, every scanned digit must be one-cold and show the right segment.
   task automatic check_frame(input string tag, input int exp_dig, input logic [6:0] exp_seg);
      int         idx;
      logic [3:0] one;
      tick_n(9);
      for (int c = 0; c < 8; c++) begin
         idx = -1;
         for (int d = 0; d < N_DIG; d++) begin
            one = 4'b0001 << d;
            if (bus.anode == ~one) idx = d;
         end
         chk({tag, " one-cold"}, 32'(idx >= 0), 1);
         if (idx >= 0) chk({tag, " disp"}, bus.disp, (idx == exp_dig) ? exp_seg : SEG_BLANK);
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      bus.en   = 1'b0;
      bus.dir  = 1'b0;
      bus.mode = MODE_SPIN;

      tick_n(3);
      chk("reset disp", bus.disp, 7'h7F);
      chk("reset anode", bus.anode, 4'hF);
      chk("reset pos", bus.pos, 0);
      chk("reset step cnt", dut.u_step.cnt, 0);
      chk("reset scan cnt", dut.u_scan.cnt, 0);

      rst_n = 1'b1;
      n = 0;
      while (bus.anode == 4'hF && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("first scan anode", bus.anode, 4'b1110);

      check_frame("spin p0", 0, SEG_A);
      for (int i = 0; i < 6; i++) begin
         step_once("spin");
         chk("spin pos", bus.pos, (i + 1) % 6);
         check_frame("spin", 0, spin_exp[(i + 1) % 6]);
      end

      bus.mode = MODE_PERIM;
      bus.dir  = 1'b1;
      @(negedge clk);
      chk("perim entry pos", bus.pos, 0);
      chk("perim entry cnt", dut.u_step.cnt, 0);
      step_once("perim rev1");
      chk("perim rev pos11", bus.pos, 11);
      check_frame("perim f3", 3, 7'b1111101);
      step_once("perim rev2");
      chk("perim rev pos10", bus.pos, 10);
      check_frame("perim e3", 3, 7'b1111011);
      bus.dir = 1'b0;
      step_once("perim fwd1");
      chk("perim fwd pos11", bus.pos, 11);
      step_once("perim fwd2");
      chk("perim wrap pos0", bus.pos, 0);
      check_frame("perim a3", 3, 7'b0111111);
      for (int i = 0; i < 7; i++) step_once("perim run");
      chk("perim pos7", bus.pos, 7);
      check_frame("perim d1", 1, 7'b1110111);

      bus.en = 1'b1;
      tick_n(2);
      chk("mid-count cnt", dut.u_step.cnt, 2);
      bus.mode = MODE_SPIN;
      @(negedge clk);
      bus.en = 1'b0;
      chk("mode switch pos", bus.pos, 0);
      chk("mode switch cnt", dut.u_step.cnt, 0);

      bus.mode = MODE_BOUNCE;
      @(negedge clk);
      chk("bounce entry pos", bus.pos, 0);
      check_frame("bounce 0", bounce_dig[0], SEG_G);
      for (int i = 1; i < 8; i++) begin
         step_once("bounce");
         check_frame("bounce", bounce_dig[i], SEG_G);
      end
      bus.dir = 1'b1;
      step_once("bounce dir ignored");
      check_frame("bounce dir ignored", 1, SEG_G);
      bus.dir = 1'b0;

      bus.mode = MODE_SPIN;
      @(negedge clk);
      chk("pause entry pos", bus.pos, 0);
      bus.en = 1'b1;
      tick_n(2);
      bus.en = 1'b0;
      tick_n(20);
      chk("pause pos held", bus.pos, 0);
      chk("pause cnt held", dut.u_step.cnt, 2);
      bus.en = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.pos == 0 && n < 20);
      bus.en = 1'b0;
      chk("resume cycles", n, 2);
      chk("resume pos", bus.pos, 1);

      bus.mode = MODE_BLANK;
      bus.en   = 1'b1;
      tick_n(12);
      chk("blank pos", bus.pos, 0);
      check_frame("blank", -1, SEG_BLANK);
      bus.en = 1'b0;

      bus.mode = MODE_SPIN;
      bus.en   = 1'b1;
      tick_n(15);
      chk("pre-reset pos", bus.pos, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset disp", bus.disp, 7'h7F);
      chk("async reset anode", bus.anode, 4'hF);
      chk("async reset pos", bus.pos, 0);
      chk("async reset cnt", dut.u_step.cnt, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      bus.en = 1'b0;
      tick_n(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
